// File: rtl/spio_hss_multiplexer_ctr_bank.sv
// ----------------------------------------------------------------------------
// spio_hss_multiplexer_ctr_bank
//
// Statistics counter bank for the HSS multiplexer. Each bit of ctr_evt drives
// one counter that either saturates or wraps at its maximum and sets a sticky
// overflow flag when an event arrives at that maximum. A FREEZE bit snapshots
// all live counters into shadows so software can read a coherent set. A CLEAR
// command zeroes the live counters. Access is through the same simple register
// interface as the neighbouring register bank.
//
// Address map (A = NUM_CTRS):
//   0..A-1  counter i (shadow while FREEZE=1), zero-extended, read-only
//   A       CTRL: bit0 FREEZE (R/W), bit1 CLEAR (write-only, reads 0)
//   A+1     OVFL: sticky overflow flags, write-1-to-clear
//   A+2     ENAB: per-counter enable mask, R/W
//   other   reads all ones, writes ignored
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ctr_evt         one-cycle event strobes, one bit per counter
//   reg_write       register write strobe
//   reg_read        register read strobe
//   reg_addr        register address
//   reg_write_data  register write data
//   reg_read_data   registered read data (1-cycle latency, holds when idle)
//   reg_read_vld    one-cycle valid for reg_read_data
// ----------------------------------------------------------------------------
module spio_hss_multiplexer_ctr_bank #(
    parameter int NUM_CTRS  = 16,
    parameter int CTR_BITS  = 32,
    parameter int REGA_BITS = 5,
    parameter int REGD_BITS = 32,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CTRS-1:0]  ctr_evt,
    input  logic                 reg_write,
    input  logic                 reg_read,
    input  logic [REGA_BITS-1:0] reg_addr,
    input  logic [REGD_BITS-1:0] reg_write_data,
    output logic [REGD_BITS-1:0] reg_read_data,
    output logic                 reg_read_vld
);

    localparam logic [REGA_BITS-1:0] ADDR_CTRL = REGA_BITS'(NUM_CTRS);
    localparam logic [REGA_BITS-1:0] ADDR_OVFL = REGA_BITS'(NUM_CTRS + 1);
    localparam logic [REGA_BITS-1:0] ADDR_ENAB = REGA_BITS'(NUM_CTRS + 2);
    localparam logic [CTR_BITS-1:0]  CTR_MAX   = '1;

    logic [CTR_BITS-1:0]  r_ctr    [NUM_CTRS];
    logic [CTR_BITS-1:0]  r_shadow [NUM_CTRS];
    logic [NUM_CTRS-1:0]  r_ovfl;
    logic [NUM_CTRS-1:0]  r_enab;
    logic                 r_freeze;
    logic [REGD_BITS-1:0] r_rd_data;
    logic                 r_rd_vld;

    logic                 w_wr_ctrl;
    logic                 w_clear;
    logic                 w_freeze_rise;
    logic                 w_wr_ovfl;
    logic                 w_wr_enab;
    logic [NUM_CTRS-1:0]  w_evt;
    logic [NUM_CTRS-1:0]  w_at_max;
    logic [NUM_CTRS-1:0]  w_ovfl_set;
    logic [REGD_BITS-1:0] w_rd_mux;
    logic                 w_unused;

    // Upper write-data bits beyond the counter count carry no meaning.
    assign w_unused = ^reg_write_data;

    assign w_wr_ctrl     = reg_write && (reg_addr == ADDR_CTRL);
    assign w_wr_ovfl     = reg_write && (reg_addr == ADDR_OVFL);
    assign w_wr_enab     = reg_write && (reg_addr == ADDR_ENAB);
    assign w_clear       = w_wr_ctrl && reg_write_data[1];
    assign w_freeze_rise = w_wr_ctrl && reg_write_data[0] && !r_freeze;
    assign w_evt         = ctr_evt & r_enab;

    // An event swallowed by CLEAR is lost entirely, so it cannot flag overflow.
    assign w_ovfl_set    = w_evt & w_at_max & {NUM_CTRS{!w_clear}};

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_at_max = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            w_at_max[i] = (r_ctr[i] == CTR_MAX);
        end
    end

    // Read mux works on current state only, so a same-cycle write is not seen.
    always_comb begin
        w_rd_mux = '1;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (reg_addr == REGA_BITS'(i)) begin
                w_rd_mux = REGD_BITS'(r_freeze ? r_shadow[i] : r_ctr[i]);
            end
        end
        if (reg_addr == ADDR_CTRL) w_rd_mux = REGD_BITS'(r_freeze);
        if (reg_addr == ADDR_OVFL) w_rd_mux = REGD_BITS'(r_ovfl);
        if (reg_addr == ADDR_ENAB) w_rd_mux = REGD_BITS'(r_enab);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter and shadow arrays are flops with defined reset
            // values, so they are cleared element by element like any register.
            for (int i = 0; i < NUM_CTRS; i++) begin
                r_ctr[i]    <= '0;
                r_shadow[i] <= '0;
            end
            r_ovfl    <= '0;
            r_enab    <= '1;
            r_freeze  <= 1'b0;
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                if (w_clear) begin
                    r_ctr[i] <= '0;
                end else if (w_evt[i]) begin
                    if (w_at_max[i]) begin
                        r_ctr[i] <= (SATURATE != 0) ? CTR_MAX : '0;
                    end else begin
                        r_ctr[i] <= r_ctr[i] + CTR_BITS'(1);
                    end
                end
                // Snapshot takes the value before this cycle's increment/clear.
                if (w_freeze_rise) begin
                    r_shadow[i] <= r_ctr[i];
                end
            end

            if (w_wr_ctrl) begin
                r_freeze <= reg_write_data[0];
            end
            if (w_wr_enab) begin
                r_enab <= reg_write_data[NUM_CTRS-1:0];
            end

            // Set wins over a simultaneous write-1-to-clear.
            if (w_wr_ovfl) begin
                r_ovfl <= (r_ovfl & ~reg_write_data[NUM_CTRS-1:0]) | w_ovfl_set;
            end else begin
                r_ovfl <= r_ovfl | w_ovfl_set;
            end

            r_rd_vld <= reg_read;
            if (reg_read) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign reg_read_data = r_rd_data;
    assign reg_read_vld  = r_rd_vld;

endmodule

// File: tb/tb_spio_hss_multiplexer_ctr_bank.sv
// ----------------------------------------------------------------------------
// tb_spio_hss_multiplexer_ctr_bank
//
// Directed bench for the statistics counter bank. Three instances share the
// register bus: u_dut (16 x 32-bit, saturating) carries most scenarios, while
// u_sat and u_wrap (16 x 4-bit, saturating / wrapping) exercise the counter
// boundary. Events for the 4-bit instances come from their own strobe vector.
// ----------------------------------------------------------------------------
module tb_spio_hss_multiplexer_ctr_bank;

    logic        clk;
    logic        rst_n;
    logic [15:0] ctr_evt;
    logic [15:0] evt_s;
    logic        reg_write;
    logic        reg_read;
    logic [4:0]  reg_addr;
    logic [31:0] reg_write_data;
    logic [31:0] rd0, rd1, rd2;
    logic        vld0, vld1, vld2;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] A_CTRL = 5'd16;
    localparam logic [4:0] A_OVFL = 5'd17;
    localparam logic [4:0] A_ENAB = 5'd18;

    spio_hss_multiplexer_ctr_bank u_dut (
        .clk(clk), .rst_n(rst_n), .ctr_evt(ctr_evt),
        .reg_write(reg_write), .reg_read(reg_read), .reg_addr(reg_addr),
        .reg_write_data(reg_write_data), .reg_read_data(rd0), .reg_read_vld(vld0)
    );

    spio_hss_multiplexer_ctr_bank #(.CTR_BITS(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .ctr_evt(evt_s),
        .reg_write(reg_write), .reg_read(reg_read), .reg_addr(reg_addr),
        .reg_write_data(reg_write_data), .reg_read_data(rd1), .reg_read_vld(vld1)
    );

    spio_hss_multiplexer_ctr_bank #(.CTR_BITS(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .ctr_evt(evt_s),
        .reg_write(reg_write), .reg_read(reg_read), .reg_addr(reg_addr),
        .reg_write_data(reg_write_data), .reg_read_data(rd2), .reg_read_vld(vld2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one read on instance sel, then check valid and data one cycle later.
    task automatic rd_chk(input string tag, input int sel, input logic [4:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        @(negedge clk);
        reg_read = 1'b1;
        reg_addr = a;
        @(negedge clk);
        reg_read = 1'b0;
        case (sel)
            1:       begin d = rd1; v = vld1; end
            2:       begin d = rd2; v = vld2; end
            default: begin d = rd0; v = vld0; end
        endcase
        check({tag, ".vld"}, 32'(v), 32'd1);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_write      = 1'b1;
        reg_addr       = a;
        reg_write_data = d;
        @(negedge clk);
        reg_write      = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] m, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ctr_evt = m;
            @(negedge clk);
            ctr_evt = '0;
        end
    endtask

    task automatic pulse_s(input logic [15:0] m, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            evt_s = m;
            @(negedge clk);
            evt_s = '0;
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        ctr_evt        = '0;
        evt_s          = '0;
        reg_write      = 1'b0;
        reg_read       = 1'b0;
        reg_addr       = '0;
        reg_write_data = '0;
        repeat (2) @(negedge clk);
        check("rst_vld", 32'(vld0), 32'd0);
        check("rst_data", rd0, 32'd0);
        rst_n = 1'b1;

        // Reset values of every counter and the control registers.
        for (int i = 0; i < 16; i++) begin
            rd_chk($sformatf("rst_ctr%0d", i), 0, 5'(i), 32'd0);
        end
        rd_chk("rst_enab", 0, A_ENAB, 32'h0000_FFFF);
        rd_chk("rst_ovfl", 0, A_OVFL, 32'd0);
        rd_chk("rst_ctrl", 0, A_CTRL, 32'd0);
        @(negedge clk);
        check("vld_one_cycle", 32'(vld0), 32'd0);
        check("data_hold", rd0, 32'd0);

        // Five events on counter 3.
        pulse(16'h0008, 5);
        rd_chk("ctr3_five", 0, 5'd3, 32'd5);
        rd_chk("ctr0_zero", 0, 5'd0, 32'd0);
        rd_chk("ctr4_zero", 0, 5'd4, 32'd0);
        rd_chk("unmapped", 0, 5'd19, 32'hFFFF_FFFF);
        rd_chk("unmapped_top", 0, 5'd31, 32'hFFFF_FFFF);

        // 4-bit counters: 17 events saturate at 15 or wrap to 1.
        pulse_s(16'h0002, 17);
        rd_chk("sat_ctr1", 1, 5'd1, 32'd15);
        rd_chk("sat_ovfl", 1, A_OVFL, 32'h0000_0002);
        rd_chk("wrap_ctr1", 2, 5'd1, 32'd1);
        rd_chk("wrap_ovfl", 2, A_OVFL, 32'h0000_0002);
        // W1C on the same cycle as a new overflow on u_sat: the flag stays set.
        // u_wrap sees no overflow that cycle, so its flag clears.
        @(negedge clk);
        evt_s          = 16'h0002;
        reg_write      = 1'b1;
        reg_addr       = A_OVFL;
        reg_write_data = 32'h0000_0002;
        @(negedge clk);
        evt_s     = '0;
        reg_write = 1'b0;
        rd_chk("sat_ovfl_setwins", 1, A_OVFL, 32'h0000_0002);
        rd_chk("wrap_ovfl_w1c", 2, A_OVFL, 32'd0);
        rd_chk("wrap_ctr1_two", 2, 5'd1, 32'd2);
        rd_chk("sat_ctr1_hold", 1, 5'd1, 32'd15);
        wr(A_OVFL, 32'h0000_0002);
        rd_chk("sat_ovfl_w1c", 1, A_OVFL, 32'd0);

        // Freeze on the same cycle as an event: shadow 7, live 8.
        pulse(16'h0020, 7);
        @(negedge clk);
        ctr_evt        = 16'h0020;
        reg_write      = 1'b1;
        reg_addr       = A_CTRL;
        reg_write_data = 32'h0000_0001;
        @(negedge clk);
        ctr_evt   = '0;
        reg_write = 1'b0;
        rd_chk("frz_shadow7", 0, 5'd5, 32'd7);
        rd_chk("frz_ctrl", 0, A_CTRL, 32'd1);
        pulse(16'h0020, 3);
        rd_chk("frz_still7", 0, 5'd5, 32'd7);
        wr(A_CTRL, 32'd0);
        rd_chk("unfrz_live11", 0, 5'd5, 32'd11);

        // Clear on the same cycle as an event on counter 0.
        pulse(16'h0001, 3);
        rd_chk("ctr0_three", 0, 5'd0, 32'd3);
        @(negedge clk);
        ctr_evt        = 16'h0001;
        reg_write      = 1'b1;
        reg_addr       = A_CTRL;
        reg_write_data = 32'h0000_0002;
        @(negedge clk);
        ctr_evt   = '0;
        reg_write = 1'b0;
        rd_chk("clr_ctr0", 0, 5'd0, 32'd0);
        rd_chk("clr_ctr5", 0, 5'd5, 32'd0);
        rd_chk("clr_ctrl_reads0", 0, A_CTRL, 32'd0);

        // Clear and freeze together: shadow keeps 9, live becomes 0.
        pulse(16'h0001, 9);
        wr(A_CTRL, 32'h0000_0003);
        rd_chk("clrfrz_shadow9", 0, 5'd0, 32'd9);
        rd_chk("clrfrz_ctrl", 0, A_CTRL, 32'd1);
        wr(A_CTRL, 32'd0);
        rd_chk("clrfrz_live0", 0, 5'd0, 32'd0);

        // Read and write ENAB in the same cycle: read returns the old mask.
        @(negedge clk);
        reg_write      = 1'b1;
        reg_read       = 1'b1;
        reg_addr       = A_ENAB;
        reg_write_data = 32'h0000_FFFB;
        @(negedge clk);
        reg_write = 1'b0;
        reg_read  = 1'b0;
        check("rdwr_vld", 32'(vld0), 32'd1);
        check("rdwr_old", rd0, 32'h0000_FFFF);
        rd_chk("enab_new", 0, A_ENAB, 32'h0000_FFFB);

        // Counter 2 masked, counter 1 enabled.
        pulse(16'h0006, 4);
        rd_chk("masked_ctr2", 0, 5'd2, 32'd0);
        rd_chk("enabled_ctr1", 0, 5'd1, 32'd4);

        // Back-to-back reads: one valid per cycle.
        @(negedge clk);
        reg_read = 1'b1;
        reg_addr = 5'd1;
        @(negedge clk);
        reg_addr = 5'd3;
        check("b2b_vld0", 32'(vld0), 32'd1);
        check("b2b_data0", rd0, 32'd4);
        @(negedge clk);
        reg_read = 1'b0;
        check("b2b_vld1", 32'(vld0), 32'd1);
        check("b2b_data1", rd0, 32'd0);

        // Reset while a read result is valid.
        @(negedge clk);
        reg_read = 1'b1;
        reg_addr = 5'd1;
        @(posedge clk);
        #1;
        check("pre_rst_vld", 32'(vld0), 32'd1);
        check("pre_rst_data", rd0, 32'd4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(vld0), 32'd0);
        check("mid_rst_data", rd0, 32'd0);
        reg_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post_rst_ctr1", 0, 5'd1, 32'd0);
        rd_chk("post_rst_ctr5", 0, 5'd5, 32'd0);
        rd_chk("post_rst_enab", 0, A_ENAB, 32'h0000_FFFF);
        rd_chk("post_rst_sat_ctr1", 1, 5'd1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
